// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the unified-memory arbiter.
package mem_arbiter_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   typedef enum logic {
      OWN_FETCH = 1'b0,
      OWN_DATA  = 1'b1
   } owner_t;

   // Memory occupancy per access, in cycles (legal 1..15).
   localparam int DEFAULT_LATENCY = 2;

   // Wait-state counter width; wide enough for the maximum latency of 15.
   localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported, fixed-latency memory between the
// instruction-fetch port and the load/store port of the core.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | memory free; grant an eligible port at this edge, if any
//   ST_BUSY | access in flight; cnt counts down the remaining wait states
//
// A port whose ready is high this cycle is not eligible at the coming edge,
// so a request still held in its completion cycle is not serviced twice.
// Data normally wins, but a fetch pending after a data grant takes the next
// slot so that a stream of loads/stores cannot starve instruction fetch.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int LATENCY = DEFAULT_LATENCY
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ready,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ready,
   output logic              d_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_re,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall
);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   owner_t            last_grant_q, last_grant_d;
   owner_t            owner_q, owner_d;
   logic              op_write_q, op_write_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              mem_re_q, mem_re_d;
   logic              mem_we_q, mem_we_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic              if_ready_q, if_ready_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              d_ready_q, d_ready_d;
   logic              d_err_q, d_err_d;

   logic              d_req;
   logic              if_elig;
   logic              d_elig;
   logic              grant_data;

   assign d_req      = d_read | d_write;
   assign if_elig    = if_req & ~if_ready_q;
   assign d_elig     = d_req & ~d_ready_q;
   assign grant_data = d_elig & ~(if_elig & (last_grant_q == OWN_DATA));

   // Next-state, grant and wait-state counter logic.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      last_grant_d = last_grant_q;
      owner_d      = owner_q;
      op_write_d   = op_write_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_re_d     = 1'b0;
      mem_we_d     = 1'b0;
      if_rdata_d   = if_rdata_q;
      if_ready_d   = 1'b0;
      d_rdata_d    = d_rdata_q;
      d_ready_d    = 1'b0;
      // Simultaneous read and write is executed as a write and flagged.
      d_err_d      = d_err_q | (d_read & d_write);

      case (state_q)
         ST_IDLE: begin
            if (if_elig | d_elig) begin
               state_d = ST_BUSY;
               cnt_d   = CNT_W'(LATENCY);
               if (grant_data) begin
                  owner_d      = OWN_DATA;
                  last_grant_d = OWN_DATA;
                  op_write_d   = d_write;
                  mem_addr_d   = d_addr;
                  mem_wdata_d  = d_wdata;
                  mem_re_d     = ~d_write;
                  mem_we_d     = d_write;
               end else begin
                  owner_d      = OWN_FETCH;
                  last_grant_d = OWN_FETCH;
                  op_write_d   = 1'b0;
                  mem_addr_d   = if_addr;
                  mem_re_d     = 1'b1;
               end
            end
         end
         ST_BUSY: begin
            cnt_d    = cnt_q - CNT_W'(1);
            mem_re_d = ~op_write_q;
            if (cnt_q == CNT_W'(1)) begin
               state_d  = ST_IDLE;
               mem_re_d = 1'b0;
               if (owner_q == OWN_DATA) begin
                  d_ready_d = 1'b1;
                  if (!op_write_q) begin
                     d_rdata_d = mem_rdata;
                  end
               end else begin
                  if_ready_d = 1'b1;
                  if_rdata_d = mem_rdata;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, counter and registered outputs; reset aborts any access at once.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         last_grant_q <= OWN_FETCH;
         owner_q      <= OWN_FETCH;
         op_write_q   <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_re_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         if_rdata_q   <= '0;
         if_ready_q   <= 1'b0;
         d_rdata_q    <= '0;
         d_ready_q    <= 1'b0;
         d_err_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         last_grant_q <= last_grant_d;
         owner_q      <= owner_d;
         op_write_q   <= op_write_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_re_q     <= mem_re_d;
         mem_we_q     <= mem_we_d;
         if_rdata_q   <= if_rdata_d;
         if_ready_q   <= if_ready_d;
         d_rdata_q    <= d_rdata_d;
         d_ready_q    <= d_ready_d;
         d_err_q      <= d_err_d;
      end
   end

   assign if_rdata  = if_rdata_q;
   assign if_ready  = if_ready_q;
   assign d_rdata   = d_rdata_q;
   assign d_ready   = d_ready_q;
   assign d_err     = d_err_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_re    = mem_re_q;
   assign mem_we    = mem_we_q;

   // Gated by reset so the core is released the moment reset is applied.
   assign stall = reset & ((if_req & ~if_ready_q) | (d_req & ~d_ready_q));

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, multi-cycle
// corner sequences, a LATENCY=1 instance and a randomized run against a
// transaction-level reference model.
module tb_mem_arbiter;

   localparam int LAT = 2;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   always #5 clock = ~clock;

   // Main instance (LATENCY=2)
   logic        if_req, d_read, d_write;
   logic [31:0] if_addr, d_addr, d_wdata;
   logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        if_ready, d_ready, d_err, mem_re, mem_we, stall;

   // Second instance (LATENCY=1)
   logic        if_req_1, d_read_1, d_write_1;
   logic [31:0] if_addr_1, d_addr_1, d_wdata_1;
   logic [31:0] if_rdata_1, d_rdata_1, mem_addr_1, mem_wdata_1, mem_rdata_1;
   logic        if_ready_1, d_ready_1, d_err_1, mem_re_1, mem_we_1, stall_1;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(LAT)) u_dut (
      .clock(clock), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ready(d_ready), .d_err(d_err),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
      .mem_rdata(mem_rdata), .stall(stall)
   );

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(1)) u_dut1 (
      .clock(clock), .reset(reset),
      .if_req(if_req_1), .if_addr(if_addr_1), .if_rdata(if_rdata_1), .if_ready(if_ready_1),
      .d_read(d_read_1), .d_write(d_write_1), .d_addr(d_addr_1), .d_wdata(d_wdata_1),
      .d_rdata(d_rdata_1), .d_ready(d_ready_1), .d_err(d_err_1),
      .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1), .mem_re(mem_re_1), .mem_we(mem_we_1),
      .mem_rdata(mem_rdata_1), .stall(stall_1)
   );

   // Behavioural memories, word-indexed by addr[9:2]
   logic [31:0] mem0 [256];
   logic [31:0] mem1 [256];
   logic        mem_init, pl_we, pl_sel;
   logic [7:0]  pl_idx;
   logic [31:0] pl_data;

   function automatic logic [31:0] init_word(input int i);
      return 32'hC0DE_0000 | 32'(i);
   endfunction

   always @(posedge clock) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) begin
            mem0[i] <= init_word(i);
            mem1[i] <= init_word(i);
         end
      end else if (pl_we) begin
         if (pl_sel) mem1[pl_idx] <= pl_data;
         else        mem0[pl_idx] <= pl_data;
      end else begin
         if (mem_we)   mem0[mem_addr[9:2]]   <= mem_wdata;
         if (mem_we_1) mem1[mem_addr_1[9:2]] <= mem_wdata_1;
      end
   end

   always @(negedge clock) begin
      mem_rdata   <= mem_re   ? mem0[mem_addr[9:2]]   : 32'h0;
      mem_rdata_1 <= mem_re_1 ? mem1[mem_addr_1[9:2]] : 32'h0;
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic preload(input logic sel, input logic [7:0] idx, input logic [31:0] data);
      pl_sel  = sel;
      pl_idx  = idx;
      pl_data = data;
      pl_we   = 1'b1;
      @(posedge clock);
      #1 pl_we = 1'b0;
   endtask

   // Observation window on the main instance; cycle 0 is the cycle in which
   // the caller has just driven the request.
   int          w_if_first, w_d_first, w_if_cnt, w_d_cnt, w_re_cnt, w_we_cnt;
   int          w_stall_cnt, w_stall_low;
   logic [31:0] w_if_rdata, w_d_rdata, w_acc_addr, w_we_data;
   bit          w_acc_seen;
   int          w_order[$];

   task automatic observe(input int n, input bit auto_drop);
      w_if_first = -1; w_d_first = -1; w_if_cnt = 0; w_d_cnt = 0;
      w_re_cnt = 0; w_we_cnt = 0; w_stall_cnt = 0; w_stall_low = -1;
      w_if_rdata = '0; w_d_rdata = '0; w_acc_addr = '0; w_we_data = '0;
      w_acc_seen = 1'b0;
      w_order.delete();
      for (int k = 0; k < n; k++) begin
         if (k > 0) @(negedge clock);
         #1;
         if (if_ready) begin
            if (w_if_first < 0) w_if_first = k;
            w_if_cnt++; w_if_rdata = if_rdata; w_order.push_back(0);
         end
         if (d_ready) begin
            if (w_d_first < 0) w_d_first = k;
            w_d_cnt++; w_d_rdata = d_rdata; w_order.push_back(1);
         end
         if ((mem_re || mem_we) && !w_acc_seen) begin
            w_acc_seen = 1'b1; w_acc_addr = mem_addr;
         end
         if (mem_re) w_re_cnt++;
         if (mem_we) begin w_we_cnt++; w_we_data = mem_wdata; end
         if (stall) w_stall_cnt++;
         else if (w_stall_low < 0) w_stall_low = k;
         if (auto_drop) begin
            if (if_ready) if_req = 1'b0;
            if (d_ready) begin d_read = 1'b0; d_write = 1'b0; end
         end
      end
   endtask

   task automatic run1(input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, output int first,
                       output logic [31:0] rdata, output int re_cnt, output int we_cnt);
      first = -1; rdata = '0; re_cnt = 0; we_cnt = 0;
      @(negedge clock);
      d_read_1 = rd; d_write_1 = wr; d_addr_1 = addr; d_wdata_1 = wdata;
      for (int k = 0; k < 6; k++) begin
         if (k > 0) @(negedge clock);
         #1;
         if (d_ready_1 && first < 0) begin first = k; rdata = d_rdata_1; end
         if (mem_re_1) re_cnt++;
         if (mem_we_1) we_cnt++;
         if (d_ready_1) begin d_read_1 = 1'b0; d_write_1 = 1'b0; end
      end
   endtask

   typedef struct {
      bit          fetch;
      bit          rd;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      bit          preload;
      logic [31:0] word;
      logic [31:0] exp_rdata;
      int          exp_cyc;
   } vec_t;

   localparam int NV = 5;
   vec_t tv [NV];

   // Reference model state for the randomized run
   logic [31:0] ref_mem [256];
   int          free_at, if_done, d_done, bs, be;
   bit          last_data, b_write, pend_d_wr, pick_d, if_el, d_el;
   bit          e_ifr, e_dr, busy, e_re, e_we;
   logic [31:0] b_addr, b_wdata, pend_if, pend_d, exp_if_rdata, exp_d_rdata;

   function automatic logic [31:0] rnd_addr();
      return 32'h2000_0000 + (32'($urandom_range(31, 16)) << 2);
   endfunction

   int          f1, r1, w1;
   logic [31:0] rd1;

   initial begin
      if_req = 0; d_read = 0; d_write = 0; if_addr = '0; d_addr = '0; d_wdata = '0;
      if_req_1 = 0; d_read_1 = 0; d_write_1 = 0; if_addr_1 = '0; d_addr_1 = '0; d_wdata_1 = '0;
      mem_init = 1'b0; pl_we = 1'b0; pl_sel = 1'b0; pl_idx = '0; pl_data = '0;

      tv[0] = '{1'b1, 1'b0, 1'b0, 32'h0040_0000, 32'h0, 1'b1, 32'h2008_0005, 32'h2008_0005, 3};
      tv[1] = '{1'b0, 1'b1, 1'b0, 32'h1000_0010, 32'h0, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 3};
      tv[2] = '{1'b0, 1'b0, 1'b1, 32'h1000_0020, 32'h1234_5678, 1'b0, 32'h0, 32'hDEAD_BEEF, 3};
      tv[3] = '{1'b0, 1'b1, 1'b0, 32'h1000_0020, 32'h0, 1'b0, 32'h0, 32'h1234_5678, 3};
      tv[4] = '{1'b1, 1'b0, 1'b0, 32'h0040_0004, 32'h0, 1'b1, 32'h8C08_0004, 32'h8C08_0004, 3};

      // Memory initialisation and reset-state checks (stall must stay low in reset)
      mem_init = 1'b1;
      @(posedge clock);
      #1 mem_init = 1'b0;
      @(negedge clock);
      if_req = 1'b1; d_read = 1'b1;
      #1;
      chk("rst if_ready", 32'(if_ready), 32'h0);
      chk("rst d_ready", 32'(d_ready), 32'h0);
      chk("rst mem_re", 32'(mem_re), 32'h0);
      chk("rst mem_we", 32'(mem_we), 32'h0);
      chk("rst d_err", 32'(d_err), 32'h0);
      chk("rst stall", 32'(stall), 32'h0);
      chk("rst if_rdata", if_rdata, 32'h0);
      chk("rst d_rdata", d_rdata, 32'h0);
      chk("rst mem_addr", mem_addr, 32'h0);
      if_req = 1'b0; d_read = 1'b0;
      @(negedge clock);
      reset = 1'b1;

      // Directed single-transaction vectors
      for (int i = 0; i < NV; i++) begin
         if (tv[i].preload) preload(1'b0, tv[i].addr[9:2], tv[i].word);
         @(negedge clock);
         if (tv[i].fetch) begin
            if_req = 1'b1; if_addr = tv[i].addr;
         end else begin
            d_read = tv[i].rd; d_write = tv[i].wr; d_addr = tv[i].addr; d_wdata = tv[i].wdata;
         end
         observe(8, 1'b1);
         chk($sformatf("v%0d ready_cycle", i), 32'(tv[i].fetch ? w_if_first : w_d_first), 32'(tv[i].exp_cyc));
         chk($sformatf("v%0d ready_count", i), 32'(tv[i].fetch ? w_if_cnt : w_d_cnt), 32'd1);
         chk($sformatf("v%0d other_ready", i), 32'(tv[i].fetch ? w_d_cnt : w_if_cnt), 32'd0);
         chk($sformatf("v%0d rdata", i), tv[i].fetch ? w_if_rdata : w_d_rdata, tv[i].exp_rdata);
         chk($sformatf("v%0d mem_re_cycles", i), 32'(w_re_cnt), tv[i].wr ? 32'd0 : 32'(LAT));
         chk($sformatf("v%0d mem_we_cycles", i), 32'(w_we_cnt), tv[i].wr ? 32'd1 : 32'd0);
         chk($sformatf("v%0d mem_addr", i), w_acc_addr, tv[i].addr);
         if (tv[i].wr) chk($sformatf("v%0d mem_wdata", i), w_we_data, tv[i].wdata);
         chk($sformatf("v%0d stall_cycles", i), 32'(w_stall_cnt), 32'(tv[i].exp_cyc));
         chk($sformatf("v%0d stall_release", i), 32'(w_stall_low), 32'(tv[i].exp_cyc));
      end

      // Simultaneous fetch and load: data first, fetch immediately after
      preload(1'b0, 8'd2, 32'h2408_0001);
      @(negedge clock);
      if_req = 1'b1; if_addr = 32'h0040_0008;
      d_read = 1'b1; d_addr = 32'h1000_0010;
      observe(10, 1'b1);
      chk("sim d_ready_cycle", 32'(w_d_first), 32'd3);
      chk("sim d_rdata", w_d_rdata, 32'hDEAD_BEEF);
      chk("sim if_ready_cycle", 32'(w_if_first), 32'd6);
      chk("sim if_rdata", w_if_rdata, 32'h2408_0001);
      chk("sim stall_cycles", 32'(w_stall_cnt), 32'd6);

      // Both ports held continuously: grants alternate
      @(negedge clock);
      if_req = 1'b1; if_addr = 32'h0040_0000;
      d_read = 1'b1; d_addr = 32'h1000_0010;
      observe(12, 1'b0);
      chk("alt completions", 32'(w_order.size()), 32'd3);
      if (w_order.size() == 3) begin
         chk("alt order0", 32'(w_order[0]), 32'd1);
         chk("alt order1", 32'(w_order[1]), 32'd0);
         chk("alt order2", 32'(w_order[2]), 32'd1);
      end
      chk("alt first_data", 32'(w_d_first), 32'd3);
      chk("alt first_fetch", 32'(w_if_first), 32'd6);
      chk("alt mem_re_cycles", 32'(w_re_cnt), 32'd8);
      chk("alt stall_cycles", 32'(w_stall_cnt), 32'd12);
      // Withdraw during the last BUSY cycle of the fourth grant (a fetch)
      if_req = 1'b0; d_read = 1'b0;
      @(negedge clock);
      observe(4, 1'b0);
      chk("withdraw if_ready_cycle", 32'(w_if_first), 32'd0);
      chk("withdraw if_rdata", w_if_rdata, 32'h2008_0005);
      chk("withdraw d_ready_count", 32'(w_d_cnt), 32'd0);

      // Reset in the first BUSY cycle of a store
      @(negedge clock);
      d_write = 1'b1; d_addr = 32'h1000_00A0; d_wdata = 32'h5A5A_0F0F;
      if_req = 1'b1; if_addr = 32'h0040_0000;
      @(posedge clock);
      #2;
      chk("abort pre mem_we", 32'(mem_we), 32'h1);
      reset = 1'b0;
      #1;
      chk("abort mem_we", 32'(mem_we), 32'h0);
      chk("abort mem_re", 32'(mem_re), 32'h0);
      chk("abort d_ready", 32'(d_ready), 32'h0);
      chk("abort if_ready", 32'(if_ready), 32'h0);
      chk("abort stall", 32'(stall), 32'h0);
      d_write = 1'b0; if_req = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      if_req = 1'b1; if_addr = 32'h0040_0000;
      observe(8, 1'b1);
      chk("post_abort if_ready_cycle", 32'(w_if_first), 32'd3);
      chk("post_abort if_rdata", w_if_rdata, 32'h2008_0005);
      chk("post_abort mem_re_cycles", 32'(w_re_cnt), 32'd2);

      // Read and write together: executed as a write, sticky error
      @(negedge clock);
      d_read = 1'b1; d_write = 1'b1; d_addr = 32'h1000_0030; d_wdata = 32'hCAFE_F00D;
      observe(8, 1'b1);
      chk("err d_ready_cycle", 32'(w_d_first), 32'd3);
      chk("err mem_we_cycles", 32'(w_we_cnt), 32'd1);
      chk("err mem_re_cycles", 32'(w_re_cnt), 32'd0);
      chk("err mem_wdata", w_we_data, 32'hCAFE_F00D);
      chk("err d_err", 32'(d_err), 32'h1);
      @(negedge clock);
      d_read = 1'b1; d_addr = 32'h1000_0030;
      observe(8, 1'b1);
      chk("err readback", w_d_rdata, 32'hCAFE_F00D);
      chk("err sticky", 32'(d_err), 32'h1);
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk("err cleared", 32'(d_err), 32'h0);
      @(negedge clock);
      reset = 1'b1;

      // LATENCY=1 instance
      preload(1'b1, 8'd4, 32'h5555_AAAA);
      run1(1'b1, 1'b0, 32'h1000_0010, 32'h0, f1, rd1, r1, w1);
      chk("lat1 load ready_cycle", 32'(f1), 32'd2);
      chk("lat1 load rdata", rd1, 32'h5555_AAAA);
      chk("lat1 load mem_re_cycles", 32'(r1), 32'd1);
      run1(1'b1, 1'b1, 32'h1000_0018, 32'h0BAD_CAFE, f1, rd1, r1, w1);
      chk("lat1 store ready_cycle", 32'(f1), 32'd2);
      chk("lat1 store mem_we_cycles", 32'(w1), 32'd1);
      chk("lat1 d_err", 32'(d_err_1), 32'h1);
      run1(1'b1, 1'b0, 32'h1000_0018, 32'h0, f1, rd1, r1, w1);
      chk("lat1 readback", rd1, 32'h0BAD_CAFE);

      // Randomized traffic against the transaction-level model
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      for (int i = 0; i < 256; i++) ref_mem[i] = {16'hC0DE, 16'(i)};
      free_at = 0; if_done = -1; d_done = -1; bs = -1; be = -2;
      last_data = 1'b0; b_write = 1'b0; pend_d_wr = 1'b0;
      b_addr = '0; b_wdata = '0; pend_if = '0; pend_d = '0;
      exp_if_rdata = '0; exp_d_rdata = '0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clock);
         #1;
         e_ifr = (c == if_done);
         e_dr  = (c == d_done);
         busy  = (c >= bs) && (c <= be);
         e_re  = busy && !b_write;
         e_we  = busy && b_write && (c == bs);
         if (e_ifr) exp_if_rdata = pend_if;
         if (e_dr && !pend_d_wr) exp_d_rdata = pend_d;
         chk($sformatf("rnd c%0d if_ready", c), 32'(if_ready), 32'(e_ifr));
         chk($sformatf("rnd c%0d d_ready", c), 32'(d_ready), 32'(e_dr));
         chk($sformatf("rnd c%0d if_rdata", c), if_rdata, exp_if_rdata);
         chk($sformatf("rnd c%0d d_rdata", c), d_rdata, exp_d_rdata);
         chk($sformatf("rnd c%0d mem_re", c), 32'(mem_re), 32'(e_re));
         chk($sformatf("rnd c%0d mem_we", c), 32'(mem_we), 32'(e_we));
         chk($sformatf("rnd c%0d d_err", c), 32'(d_err), 32'h0);
         if (busy) chk($sformatf("rnd c%0d mem_addr", c), mem_addr, b_addr);
         if (e_we) chk($sformatf("rnd c%0d mem_wdata", c), mem_wdata, b_wdata);

         if (if_req && e_ifr) if_req = 1'b0;
         if (!if_req && $urandom_range(2, 0) == 0) begin
            if_req = 1'b1; if_addr = rnd_addr();
         end
         if ((d_read || d_write) && e_dr) begin d_read = 1'b0; d_write = 1'b0; end
         if (!(d_read || d_write) && $urandom_range(2, 0) == 0) begin
            d_write = 1'($urandom_range(1, 0));
            d_read  = !d_write;
            d_addr  = rnd_addr();
            d_wdata = $urandom;
         end
         #1;
         chk($sformatf("rnd c%0d stall", c), 32'(stall),
             32'((if_req && !e_ifr) || ((d_read || d_write) && !e_dr)));

         if_el = if_req && !e_ifr;
         d_el  = (d_read || d_write) && !e_dr;
         if (c >= free_at && (if_el || d_el)) begin
            pick_d    = d_el && !(if_el && last_data);
            last_data = pick_d;
            bs        = c + 1;
            be        = c + LAT;
            free_at   = c + LAT + 1;
            if (pick_d) begin
               d_done    = c + LAT + 1;
               b_write   = d_write;
               b_addr    = d_addr;
               b_wdata   = d_wdata;
               pend_d_wr = d_write;
               if (d_write) ref_mem[d_addr[9:2]] = d_wdata;
               else         pend_d = ref_mem[d_addr[9:2]];
            end else begin
               if_done = c + LAT + 1;
               b_write = 1'b0;
               b_addr  = if_addr;
               pend_if = ref_mem[if_addr[9:2]];
            end
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
